// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
//   Memory-mapped UART receive peripheral. Deserialises 8N1 frames from the
//   serial pin, holds the most recent byte in a data register and exposes the
//   byte and a status word to core loads. A load of the data address consumes
//   the byte; a load of the status address clears a latched framing error.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous, active-low reset
//   rx_serial  in   asynchronous serial line, idle high
//   address    in   load address from the MEM stage (XLEN)
//   rd_en      in   load strobe; qualifies the read side effects
//   data_out   out  combinational read data (XLEN)
//   rx_ready   out  a byte is waiting (status bit 0)
//   rx_busy    out  a frame is in progress (FSM not idle)
//
// Status word at RX_READY_ADDR: {zeros, framing_err, overrun, ready}
//
// Bus handshake: there is no valid/ready pair on the load port. data_out is
//   valid in the same cycle as address; a side effect happens only on a clock
//   edge where rd_en is 1, and its result is visible the cycle after.
// ---------------------------------------------------------------------------
module uart_receiver #(
    parameter int              XLEN          = 32,
    parameter int              CLKS_PER_BIT  = 217,
    parameter logic [XLEN-1:0] RX_DATA_ADDR  = 'h650,
    parameter logic [XLEN-1:0] RX_READY_ADDR = 'h660
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx_serial,
    input  logic [XLEN-1:0] address,
    input  logic            rd_en,
    output logic [XLEN-1:0] data_out,
    output logic            rx_ready,
    output logic            rx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic [7:0]      r_data;
    logic            r_ready;
    logic            r_overrun;
    logic            r_framing_err;
    logic            r_sync1;
    logic            r_sync2;

    logic            w_rxs;
    logic            w_rd_data;
    logic            w_rd_status;

    assign w_rxs       = r_sync2;
    assign w_rd_data   = rd_en && (address == RX_DATA_ADDR);
    assign w_rd_status = rd_en && (address == RX_READY_ADDR);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_bit_idx     <= '0;
            r_shift       <= '0;
            r_data        <= '0;
            r_ready       <= 1'b0;
            r_overrun     <= 1'b0;
            r_framing_err <= 1'b0;
            r_sync1       <= 1'b1;
            r_sync2       <= 1'b1;
        end else begin
            r_sync1 <= rx_serial;
            r_sync2 <= r_sync1;

            // Read side effects come first so that a frame event in the same
            // cycle overrides them (new byte / new framing error wins).
            if (w_rd_data) begin
                r_ready   <= 1'b0;
                r_overrun <= 1'b0;
            end
            if (w_rd_status) begin
                r_framing_err <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (!w_rxs) begin
                        r_state <= START;
                        r_cnt   <= '0;
                    end
                end
                START: begin
                    // Mid-start-bit check rejects short low glitches.
                    if (r_cnt == HALF_M1) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_state   <= w_rxs ? IDLE : DATA;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt              <= '0;
                        r_shift[r_bit_idx] <= w_rxs;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                STOP: begin
                    // Leaving at mid-stop-bit lets a following start bit be
                    // caught with no idle gap between frames.
                    if (r_cnt == FULL_M1) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                        if (w_rxs) begin
                            r_data  <= r_shift;
                            r_ready <= 1'b1;
                            // A byte consumed on this very edge is not lost.
                            r_overrun <= r_ready && !w_rd_data;
                        end else begin
                            r_framing_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        data_out = '0;
        if (address == RX_DATA_ADDR) begin
            data_out = {{(XLEN-8){1'b0}}, r_data};
        end else if (address == RX_READY_ADDR) begin
            data_out = {{(XLEN-3){1'b0}}, r_framing_err, r_overrun, r_ready};
        end
    end

    assign rx_ready = r_ready;
    assign rx_busy  = (r_state != IDLE);

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Memory-mapped UART receive peripheral: the inbound counterpart of the UART transmit path in the data memory. Deserialises 8N1 frames from the serial input pin, holds the last byte in a data register, and exposes data and status at the UART RX addresses (default 'h650 / 'h660) for core loads. Reading the data address consumes the byte.

## Interface
Parameters:
- XLEN, 32, data bus width
- CLKS_PER_BIT, 217, clock cycles per bit (25 MHz / 115200); must be ≥ 4
- RX_DATA_ADDR, 'h650, address returning received byte
- RX_READY_ADDR, 'h660, address returning status

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- rx_serial  in  1  asynchronous serial line, idle high
- address  in  XLEN  load address from the MEM stage
- rd_en  in  1  load strobe, qualifies read side effects
- data_out  out  XLEN  combinational read data
- rx_ready  out  1  byte waiting (mirror of status bit 0)
- rx_busy  out  1  frame in progress (state ≠ IDLE)

## Operation
- One clock; reset is synchronous and active-low (rst low at a clk edge resets). Reset values: state IDLE, counters 0, shift and data registers 0, ready/overrun/framing_err 0, both synchroniser flops 1.
- rx_serial passes through a 2-flop synchroniser; FSM uses only the synchronised bit rxs.
- FSM:
  - IDLE: rxs==0 → START, bit counter cleared.
  - START: count to CLKS_PER_BIT/2−1 (integer division), sample rxs: 0 → DATA (counter, bit index cleared); 1 → IDLE (glitch, nothing recorded).
  - DATA: count to CLKS_PER_BIT−1, sample rxs into shift[bit_idx], LSB first; after bit 7 → STOP.
  - STOP: count to CLKS_PER_BIT−1, sample rxs: 1 → data_reg ← shift, ready ← 1, overrun ← ready (old value); 0 → framing_err ← 1, data_reg/ready untouched. Either case → IDLE next cycle.
- Reads (data_out purely combinational on address):
  - address==RX_DATA_ADDR → {(XLEN−8) zeros, data_reg}
  - address==RX_READY_ADDR → {(XLEN−3) zeros, framing_err, overrun, ready}
  - otherwise → 0
- Side effects on the edge where rd_en=1: RX_DATA_ADDR clears ready and overrun; RX_READY_ADDR clears framing_err. No side effect with rd_en=0.
- Simultaneous stop-bit accept and data read in the same cycle: new byte wins — ready stays 1, data_reg holds new byte, overrun 0.
- Simultaneous framing error and status read: framing_err ends 1.
- Unread byte overwritten by new valid frame: data_reg takes new byte, overrun 1.
- Reset mid-frame: immediate return to IDLE, partial byte discarded; a subsequent low on rxs begins a new frame.

## Timing
- Synchroniser latency 2 cycles pin → rxs.
- From rxs falling (first IDLE cycle seeing 0): START sample at +CLKS_PER_BIT/2, data bit k sampled at +CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT, stop at +CLKS_PER_BIT/2 + 9·CLKS_PER_BIT; ready visible the following cycle.
- Back to IDLE at mid-stop bit, so back-to-back frames with one stop bit are received with no gap.
- data_out valid same cycle as address; status/data clears visible the cycle after the rd_en edge.
- Tolerates ±4% baud mismatch at nominal sampling.

## Test plan (CLKS_PER_BIT=8)
- Reset, then frame 0x55 on rx_serial → ready=1 after ≈2+4+72+1 cycles; read 'h650 → 0x00000055; next cycle read 'h660 → 0x0.
- Two back-to-back frames 0xA5, 0x3C without reading → data 0x3C, status 0x3 (overrun|ready); read 'h650 with rd_en → status 0x0.
- Low glitch of 2 cycles on idle line → FSM returns to IDLE, ready stays 0, rx_busy pulses then falls.
- Frame 0xFF with stop bit driven 0 → status 0x4, data_reg unchanged; rd_en read of 'h660 → status 0x0.
- rd_en read of 'h650 on the same cycle as stop-bit accept of 0x81 → ready=1, data 0x81, overrun 0.
- rst low mid-DATA of frame 0x12, released, then frame 0x34 → data 0x34, status 0x1; read of unmapped address 'h654 → 0.
